bitty_fetch_unit: RTL and testbench

//  Instruction fetch/sequencer upstream of bitty_core. Holds a program counter and an

---
 rtl/bitty_pkg.sv | 39 +++
 rtl/bitty_instr_mem.sv | 58 +++++
 rtl/bitty_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_bitty_fetch_unit.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch unit: FSM state encoding, branch
// opcode and condition codes, and the branch-condition evaluator.
package bitty_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERROR  = 3'd5
  } fetch_state_e;

  // Low two instruction bits that mark a locally resolved branch
  localparam logic [1:0] BRANCH_OP = 2'b11;

  // Branch condition field, instr[3:2]
  localparam logic [1:0] BR_EQZ = 2'b00;
  localparam logic [1:0] BR_GTZ = 2'b01;
  localparam logic [1:0] BR_LTZ = 2'b10;
  localparam logic [1:0] BR_ALW = 2'b11;

  // Evaluates a branch condition against the core's last ALU result,
  // treating that result as a two's-complement value.
  function automatic logic branch_taken(input logic [1:0]                cond,
                                        input logic signed [INSTR_W-1:0] val);
    logic taken;
    case (cond)
      BR_EQZ:  taken = (val == 16'sd0);
      BR_GTZ:  taken = (val > 16'sd0);
      BR_LTZ:  taken = (val < 16'sd0);
      default: taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/bitty_instr_mem.sv
// Instruction memory: DEPTH x 16 RAM with one write port and one registered
// read port. The read register only updates when re is high, so the fetched
// word stays on rdata until the next fetch.
module bitty_instr_mem
  import bitty_pkg::*;
#(
  parameter int    ADDR_W   = 8,
  parameter int    DEPTH    = 256,
  parameter string MEM_INIT = ""
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rdata_q;
  logic [INSTR_W-1:0] rdata_d;

  // Elaboration-time contents: zeroed
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  // Write port; array storage is never reset
  always @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-data next value: load on a fetch, otherwise hold
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read-data register, cleared by reset so the instruction bus reads 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch/sequencer in front of bitty_core. Fetches one word at a
// time, issues non-branch words to the core with a one-cycle run pulse, waits
// for core_done, resolves branches locally and watches for a stuck core.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int                 ADDR_W    = 8,
  parameter int                 DEPTH     = 256,
  parameter string              MEM_INIT  = "",
  parameter logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF,
  parameter int                 TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               core_done,
  input  logic [INSTR_W-1:0] last_alu_result,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               run,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  // Watchdog counter is just wide enough to reach TIMEOUT
  localparam int                WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(DEPTH - 1);

  fetch_state_e        state_q;
  fetch_state_e        state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [WD_W-1:0]     wd_q;
  logic [WD_W-1:0]     wd_d;

  logic [INSTR_W-1:0]  instr_q;
  logic                mem_re;
  logic                mem_we;
  logic                idle_like;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   br_target;
  logic [WD_W-1:0]     wd_inc;

  // Memory is only writable while nothing is executing
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALTED) ||
                     (state_q == ST_ERROR);
  assign mem_we    = load_en && idle_like;

  bitty_instr_mem #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .MEM_INIT (MEM_INIT)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (pc_q),
    .rdata (instr_q)
  );

  // Sequential PC wraps at DEPTH; branch target is instr[11:4] fitted to ADDR_W
  assign pc_inc    = (pc_q == PC_LAST) ? '0 : pc_q + ADDR_W'(1);
  assign br_target = ADDR_W'(instr_q[11:4]);
  assign wd_inc    = wd_q + WD_W'(1);

  // Next-state, PC, watchdog and run decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    run     = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_re  = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The halt word also has branch low bits, so it is tested first
        if (instr_q == HALT_WORD) begin
          state_d = ST_HALTED;
        end else if (instr_q[1:0] == BRANCH_OP) begin
          pc_d    = branch_taken(instr_q[3:2], last_alu_result) ? br_target : pc_inc;
          state_d = ST_FETCH;
        end else begin
          run     = 1'b1;
          wd_d    = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion beats the watchdog on the expiry cycle
        if (core_done) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else begin
          wd_d = wd_inc;
          if ((TIMEOUT != 0) && (wd_inc == WD_LIMIT)) begin
            state_d = ST_ERROR;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                       (state_q == ST_WAIT);
  assign halted      = (state_q == ST_HALTED);
  assign error       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: directed scenarios plus random
// programs compared against an instruction-level reference model.
module tb_bitty_fetch_unit;

  localparam logic [15:0] HALT = 16'hFFFF;
  localparam int          TMO  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        core_done = 1'b0;
  logic [15:0] last_alu_result = 16'h0000;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'h00;
  logic [15:0] load_data = 16'h0000;
  logic        run;
  logic [15:0] instruction;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem_model [256];

  always #5 clk = ~clk;

  bitty_fetch_unit #(
    .ADDR_W    (8),
    .DEPTH     (256),
    .MEM_INIT  (""),
    .HALT_WORD (HALT),
    .TIMEOUT   (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .core_done       (core_done),
    .last_alu_result (last_alu_result),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .run             (run),
    .instruction     (instruction),
    .pc              (pc),
    .busy            (busy),
    .halted          (halted),
    .error           (error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; start = 1'b0; core_done = 1'b0; load_en = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
    mem_model[a] = d;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    if ($urandom_range(0, 9) < 6) begin
      w = 16'($urandom);
      if (w[1:0] == 2'b11) w[1:0] = 2'b01;
    end else begin
      w = {4'($urandom), 8'($urandom_range(0, 31)), 2'($urandom), 2'b11};
    end
    return w;
  endfunction

  function automatic logic [15:0] pick_alu();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset;
    do_reset;
    checks++;
    if (run !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl run=%b busy=%b halted=%b error=%b required all 0", run, busy, halted, error);
    end
    checks++;
    if (pc !== 8'h00 || instruction !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data pc=%h instr=%h required pc=00 instr=0000", pc, instruction);
    end
    load_word(8'd0, 16'h007F);
    load_word(8'd7, 16'h1231);
    start = 1'b1; tick; start = 1'b0;
    repeat (3) tick;
    checks++;
    if (run !== 1'b1 || pc !== 8'h07 || instruction !== 16'h1231) begin
      errors++;
      $display("FAIL reset_pre_issue run=%b pc=%h instr=%h required run=1 pc=07 instr=1231", run, pc, instruction);
    end
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (run !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || instruction !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_wait run=%b busy=%b pc=%h instr=%h required 0 0 00 0000", run, busy, pc, instruction);
    end
    tick;
    reset = 1'b1;
    tick;
    checks++;
    if (run !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || error !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle_after run=%b busy=%b halted=%b error=%b pc=%h required idle at pc 00", run, busy, halted, error, pc);
    end
  endtask

  task automatic test_sequence;
    int runs;
    do_reset;
    load_word(8'd0, 16'h1234);
    load_word(8'd1, 16'h5678);
    load_word(8'd2, HALT);
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if (run !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL seq_fetch run=%b busy=%b required run=0 busy=1", run, busy);
    end
    tick;
    checks++;
    if (run !== 1'b1 || instruction !== 16'h1234 || pc !== 8'h00) begin
      errors++;
      $display("FAIL seq_issue0 run=%b instr=%h pc=%h required 1 1234 00", run, instruction, pc);
    end
    tick; tick; tick;
    checks++;
    if (run !== 1'b0 || instruction !== 16'h1234 || busy !== 1'b1) begin
      errors++;
      $display("FAIL seq_wait_hold run=%b instr=%h busy=%b required 0 1234 1", run, instruction, busy);
    end
    core_done = 1'b1; tick; core_done = 1'b0;
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL seq_gap run=%b required 0", run);
    end
    tick;
    checks++;
    if (run !== 1'b1 || instruction !== 16'h5678 || pc !== 8'h01) begin
      errors++;
      $display("FAIL seq_issue1 run=%b instr=%h pc=%h required 1 5678 01", run, instruction, pc);
    end
    tick;
    core_done = 1'b1; tick; core_done = 1'b0;
    tick;
    runs = (run === 1'b1) ? 1 : 0;
    tick;
    checks++;
    if (halted !== 1'b1 || pc !== 8'h02 || busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_halt halted=%b pc=%h busy=%b required 1 02 0", halted, pc, busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (run === 1'b1) runs++;
      tick;
    end
    checks++;
    if (runs != 0) begin
      errors++;
      $display("FAIL seq_no_third_run runs=%0d required 0", runs);
    end
  endtask

  task automatic test_branch;
    logic [15:0] words [6];
    logic [15:0] alus  [6];
    logic [7:0]  exps  [6];
    int runs;
    words = '{16'h0203, 16'h0203, 16'h020B, 16'h0207, 16'h0207, 16'h020B};
    alus  = '{16'h0000, 16'h0001, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000};
    exps  = '{8'h20,    8'h05,    8'h20,    8'h05,    8'h20,    8'h05};
    do_reset;
    load_word(8'd0, 16'h004F);
    load_word(8'd5, HALT);
    load_word(8'h20, HALT);
    for (int c = 0; c < 6; c++) begin
      load_word(8'd4, words[c]);
      last_alu_result = alus[c];
      start = 1'b1; tick; start = 1'b0;
      runs = 0;
      for (int i = 0; i < 6; i++) begin
        if (run === 1'b1) runs++;
        tick;
      end
      checks++;
      if (halted !== 1'b1 || pc !== exps[c] || runs != 0) begin
        errors++;
        $display("FAIL branch_case%0d halted=%b pc=%h runs=%0d required halted=1 pc=%h runs=0", c, halted, pc, runs, exps[c]);
      end
    end
  endtask

  task automatic test_watchdog;
    bit ok;
    do_reset;
    load_word(8'd0, 16'h0001);
    load_word(8'd1, HALT);
    start = 1'b1; tick; start = 1'b0;
    tick;
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL wd_issue run=%b required 1", run);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (error !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wd_early error=%b busy=%b required error=0 busy=1 for 5 wait cycles", error, busy);
    end
    tick;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL wd_expire error=%b busy=%b halted=%b required 1 0 0", error, busy, halted);
    end
    start = 1'b1; tick; start = 1'b0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || pc !== 8'h00) begin
      errors++;
      $display("FAIL wd_start_clear error=%b busy=%b pc=%h required 0 1 00", error, busy, pc);
    end
    tick;
    repeat (5) tick;
    core_done = 1'b1; tick; core_done = 1'b0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || pc !== 8'h01) begin
      errors++;
      $display("FAIL wd_done_wins error=%b busy=%b pc=%h required 0 1 01", error, busy, pc);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    load_word(8'd0, 16'h0FFF);
    load_word(8'd255, 16'h0005);
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    checks++;
    if (run !== 1'b1 || pc !== 8'hFF || instruction !== 16'h0005) begin
      errors++;
      $display("FAIL wrap_issue255 run=%b pc=%h instr=%h required 1 ff 0005", run, pc, instruction);
    end
    tick;
    core_done = 1'b1; tick; core_done = 1'b0;
    checks++;
    if (pc !== 8'h00 || busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pc pc=%h busy=%b error=%b required 00 1 0", pc, busy, error);
    end
    tick;
    checks++;
    if (instruction !== 16'h0FFF || run !== 1'b0) begin
      errors++;
      $display("FAIL wrap_fetch0 instr=%h run=%b required 0fff 0", instruction, run);
    end
  endtask

  task automatic test_ignore;
    do_reset;
    core_done = 1'b1; tick; core_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || run !== 1'b0 || pc !== 8'h00 || halted !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL ign_done_idle busy=%b run=%b pc=%h halted=%b error=%b required idle", busy, run, pc, halted, error);
    end
    load_word(8'd0, 16'h0001);
    load_word(8'd1, HALT);
    start = 1'b1; tick; start = 1'b0;
    core_done = 1'b1; tick; core_done = 1'b0;
    checks++;
    if (run !== 1'b1 || pc !== 8'h00 || instruction !== 16'h0001) begin
      errors++;
      $display("FAIL ign_done_fetch run=%b pc=%h instr=%h required 1 00 0001", run, pc, instruction);
    end
    tick;
    load_en = 1'b1; load_addr = 8'd1; load_data = 16'h0002; start = 1'b1;
    tick;
    load_addr = 8'd0; load_data = 16'h0004;
    tick;
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || run !== 1'b0 || pc !== 8'h00 || instruction !== 16'h0001) begin
      errors++;
      $display("FAIL ign_busy_inputs busy=%b run=%b pc=%h instr=%h required 1 0 00 0001", busy, run, pc, instruction);
    end
    core_done = 1'b1; tick; core_done = 1'b0;
    tick; tick;
    checks++;
    if (halted !== 1'b1 || pc !== 8'h01 || instruction !== HALT) begin
      errors++;
      $display("FAIL ign_mem1_kept halted=%b pc=%h instr=%h required 1 01 ffff", halted, pc, instruction);
    end
    start = 1'b1; tick; start = 1'b0;
    tick;
    checks++;
    if (run !== 1'b1 || instruction !== 16'h0001) begin
      errors++;
      $display("FAIL ign_mem0_kept run=%b instr=%h required 1 0001", run, instruction);
    end
  endtask

  task automatic test_load_start;
    do_reset;
    load_en = 1'b1; load_addr = 8'd0; load_data = 16'h0100; start = 1'b1;
    tick;
    load_en = 1'b0; start = 1'b0;
    mem_model[0] = 16'h0100;
    tick;
    checks++;
    if (run !== 1'b1 || instruction !== 16'h0100) begin
      errors++;
      $display("FAIL load_start run=%b instr=%h required 1 0100", run, instruction);
    end
  endtask

  task automatic test_random_programs;
    logic [15:0] w;
    logic [7:0]  mpc;
    int elapsed, bexp, lat, v;
    bit fin, taken, seen_run, ok;
    for (int r = 0; r < 6; r++) begin
      do_reset;
      for (int a = 0; a < 32; a++) load_word(8'(a), rand_word());
      load_word(8'($urandom_range(4, 31)), HALT);
      last_alu_result = pick_alu();
      mpc = 8'd0; bexp = 0; fin = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      elapsed = 1;
      for (int s = 0; s < 60 && !fin; s++) begin
        w = mem_model[mpc];
        if (w == HALT) begin
          seen_run = 1'b0;
          while (halted !== 1'b1 && elapsed < 200) begin
            if (run === 1'b1) seen_run = 1'b1;
            tick; elapsed++;
          end
          checks++;
          if (halted !== 1'b1 || pc !== mpc || seen_run || elapsed != 3 + 2 * bexp) begin
            errors++;
            $display("FAIL rand_halt round=%0d halted=%b pc=%h cycles=%0d run_seen=%b required 1 %h %0d 0",
                     r, halted, pc, elapsed, seen_run, mpc, 3 + 2 * bexp);
          end
          fin = 1'b1;
        end else if (w[1:0] == 2'b11) begin
          v = int'($signed(last_alu_result));
          case (w[3:2])
            2'b00:   taken = (v == 0);
            2'b01:   taken = (v > 0);
            2'b10:   taken = (v < 0);
            default: taken = 1'b1;
          endcase
          mpc = taken ? w[11:4] : mpc + 8'd1;
          bexp++;
        end else begin
          while (run !== 1'b1 && elapsed < 200) begin
            tick; elapsed++;
          end
          checks++;
          if (run !== 1'b1 || pc !== mpc || instruction !== w || elapsed != 2 + 2 * bexp) begin
            errors++;
            $display("FAIL rand_issue round=%0d run=%b pc=%h instr=%h cycles=%0d required 1 %h %h %0d",
                     r, run, pc, instruction, elapsed, mpc, w, 2 + 2 * bexp);
            fin = 1'b1;
          end else begin
            lat = $urandom_range(1, 4);
            ok = 1'b1;
            for (int k = 0; k < lat; k++) begin
              load_en = 1'($urandom_range(0, 1));
              load_addr = 8'($urandom_range(0, 31));
              load_data = 16'($urandom);
              tick;
              if (run !== 1'b0 || busy !== 1'b1 || instruction !== w || error !== 1'b0) ok = 1'b0;
            end
            load_en = 1'b0;
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL rand_wait_hold round=%0d run=%b busy=%b instr=%h error=%b required 0 1 %h 0",
                       r, run, busy, instruction, error, w);
            end
            core_done = 1'b1;
            last_alu_result = pick_alu();
            tick;
            core_done = 1'b0;
            elapsed = 1; bexp = 0;
            mpc = mpc + 8'd1;
          end
        end
      end
    end
    do_reset;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
    test_reset;
    test_sequence;
    test_branch;
    test_watchdog;
    test_wrap;
    test_ignore;
    test_load_start;
    test_random_programs;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim time exceeded after %0d checks", checks);
    $fatal(1);
  end

endmodule
